// File: rtl/tiny_fsm_pkg.sv
// Shared types and instruction encoding for the instruction sequencer and its UART loader.
package tiny_fsm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALTED = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam int unsigned BIT_LOAD_LEFT   = 31;
    localparam int unsigned BIT_LOAD_TOP    = 30;
    localparam int unsigned BIT_SWAP_LEFT   = 29;
    localparam int unsigned BIT_SWAP_TOP    = 28;
    localparam int unsigned BIT_SHIFT_RIGHT = 27;
    localparam int unsigned BIT_SHIFT_DOWN  = 26;
    localparam int unsigned BIT_ACC_CLR     = 25;
    localparam int unsigned BIT_WRITE_OUT   = 24;
    localparam int unsigned BIT_HALT        = 21;
    localparam int unsigned BIT_NOP         = 20;

    localparam logic [31:0] INSTR_NOP  = 32'h0000_0000;
    localparam logic [31:0] INSTR_HALT = 32'h0020_0000;

    function automatic logic instr_is_halt(input logic [31:0] instr);
        return (instr & INSTR_HALT) != INSTR_NOP;
    endfunction

endpackage

// File: rtl/tiny_fsm_control_uart_rx.sv
// 8N1 UART byte receiver: two-flop synchronised input, start-edge detect, mid-bit sampling.
// A byte whose stop bit reads low is discarded (no valid pulse).
module uart_rx_byte
    import tiny_fsm_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o
);

    localparam int unsigned TMR_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TMR_W-1:0] TMR_FULL = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(CLKS_PER_BIT / 2 - 1);

    rx_state_t        rx_state_q, rx_state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             rx_meta_q, rx_sync_q, rx_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            tmr_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            rx_meta_q  <= rx_i;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            tmr_q      <= tmr_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        tmr_d      = tmr_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        valid_d    = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                // falling edge rather than low level, so a low stop bit is never mistaken for a start
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    tmr_d      = TMR_HALF;
                end
            end
            RX_START: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - 1'b1;
                end else if (!rx_sync_q) begin
                    rx_state_d = RX_DATA;
                    tmr_d      = TMR_FULL;
                    bit_idx_d  = '0;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_DATA: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - 1'b1;
                end else begin
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    tmr_d   = TMR_FULL;
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - 1'b1;
                end else begin
                    valid_d    = rx_sync_q;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign data_o  = shift_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/tiny_fsm_control.sv
// Instruction sequencer: UART-loaded instruction RAM, PC, and fetch/decode/exec FSM with debug outputs.
//  state   | meaning
//  IDLE    | waiting for run level or step rising edge; UART bytes accepted only here
//  FETCH   | latch ram[pc] and ram[pc+1]
//  DECODE  | decode the fetched word (HALT flag)
//  EXEC    | retire: pc+1, then HALTED / FETCH (run) / IDLE
//  HALTED  | sticky until reset; outputs frozen
module tiny_fsm_control
    import tiny_fsm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned MATRIX_SIZE   = 8,
    parameter int unsigned ACC_WIDTH     = 32,
    parameter int unsigned DP_ADDR_WIDTH = 10,
    parameter int unsigned INSTR_WIDTH   = 32,
    parameter int unsigned INSTR_DEPTH   = 256,
    parameter int unsigned CLKS_PER_BIT  = 434
) (
    input  logic                           clk,
    input  logic                           fsm_rst,
    input  logic                           step,
    input  logic                           run,
    input  logic                           halt,
    input  logic                           uart_rx,
    output logic                           uart_tx,
    output logic [$clog2(INSTR_DEPTH)-1:0] pc_out,
    output logic [INSTR_WIDTH-1:0]         curr_instr_out,
    output logic [INSTR_WIDTH-1:0]         next_instr_out,
    output logic [2:0]                     state_out
);

    localparam int unsigned PC_W = $clog2(INSTR_DEPTH);

    state_t                 state_q, state_d;
    logic [PC_W-1:0]        pc_q, pc_d, pc_inc;
    logic [INSTR_WIDTH-1:0] curr_q, curr_d;
    logic [INSTR_WIDTH-1:0] next_q, next_d;
    logic                   step_q, step_rise;
    logic                   halt_req_q, halt_req_d;
    logic                   halt_flag_q, halt_flag_d;

    logic [1:0]             byte_cnt_q, byte_cnt_d;
    logic [23:0]            word_q, word_d;
    logic [PC_W-1:0]        load_ptr_q, load_ptr_d;
    logic                   ram_we;
    logic [INSTR_WIDTH-1:0] ram_wdata;
    logic [7:0]             rx_data;
    logic                   rx_valid;

    logic [INSTR_WIDTH-1:0] mem [INSTR_DEPTH];

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_rx (
        .clk    (clk),
        .rst_n  (fsm_rst),
        .rx_i   (uart_rx),
        .data_o (rx_data),
        .valid_o(rx_valid)
    );

    assign pc_inc    = pc_q + 1'b1;
    assign step_rise = step && !step_q;

    always_ff @(posedge clk or negedge fsm_rst) begin
        if (!fsm_rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            curr_q      <= '0;
            next_q      <= '0;
            step_q      <= 1'b0;
            halt_req_q  <= 1'b0;
            halt_flag_q <= 1'b0;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            load_ptr_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            curr_q      <= curr_d;
            next_q      <= next_d;
            step_q      <= step;
            halt_req_q  <= halt_req_d;
            halt_flag_q <= halt_flag_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            load_ptr_q  <= load_ptr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        curr_d      = curr_q;
        next_d      = next_q;
        halt_req_d  = halt_req_q;
        halt_flag_d = halt_flag_q;
        unique case (state_q)
            ST_IDLE: begin
                halt_req_d  = 1'b0;
                halt_flag_d = 1'b0;
                if (halt) begin
                    state_d = ST_HALTED;
                end else if (run || step_rise) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                curr_d     = mem[pc_q];
                next_d     = mem[pc_inc];
                halt_req_d = halt_req_q || halt;
                state_d    = ST_DECODE;
            end
            ST_DECODE: begin
                // halt seen mid-instruction is remembered so the instruction still retires
                halt_flag_d = instr_is_halt(curr_q);
                halt_req_d  = halt_req_q || halt;
                state_d     = ST_EXEC;
            end
            ST_EXEC: begin
                pc_d = pc_inc;
                if (halt || halt_req_q || halt_flag_q) begin
                    state_d = ST_HALTED;
                end else if (run) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    // little-endian byte packer; the fourth byte goes straight to RAM with the three held ones
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        load_ptr_d = load_ptr_q;
        ram_we     = 1'b0;
        ram_wdata  = {rx_data, word_q};
        if (rx_valid && (state_q == ST_IDLE)) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            unique case (byte_cnt_q)
                2'd0: word_d[7:0]   = rx_data;
                2'd1: word_d[15:8]  = rx_data;
                2'd2: word_d[23:16] = rx_data;
                default: begin
                    ram_we     = 1'b1;
                    load_ptr_d = load_ptr_q + 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[load_ptr_q] <= ram_wdata;
        end
    end

    assign uart_tx        = 1'b1;
    assign pc_out         = pc_q;
    assign curr_instr_out = curr_q;
    assign next_instr_out = next_q;
    assign state_out      = state_q;

endmodule

// File: tb/tb_tiny_fsm_control.sv
// Randomised self-checking bench for tiny_fsm_control against a RAM/PC reference model.
module tb_tiny_fsm_control;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        fsm_rst = 1'b0;
    logic        step = 1'b0;
    logic        run = 1'b0;
    logic        halt = 1'b0;
    logic        uart_rx = 1'b1;
    logic        uart_tx;
    logic [7:0]  pc_out;
    logic [31:0] curr_instr_out;
    logic [31:0] next_instr_out;
    logic [2:0]  state_out;

    int n_vec = 0;
    int n_err = 0;
    int ticks = 0;

    logic [31:0] ram_m [256];
    int          pc_m = 0;
    int          load_ptr_m = 0;
    int          bcnt_m = 0;
    logic [7:0]  bytes_m [4];

    tiny_fsm_control #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk           (clk),
        .fsm_rst       (fsm_rst),
        .step          (step),
        .run           (run),
        .halt          (halt),
        .uart_rx       (uart_rx),
        .uart_tx       (uart_tx),
        .pc_out        (pc_out),
        .curr_instr_out(curr_instr_out),
        .next_instr_out(next_instr_out),
        .state_out     (state_out)
    );

    always #10 clk = ~clk;

    initial begin
        #(20 * 95000);
        $display("FAIL watchdog: simulation did not finish, got time %0t expected earlier end", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        ticks++;
    endtask

    task automatic model_reset();
        pc_m       = 0;
        load_ptr_m = 0;
        bcnt_m     = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        bytes_m[bcnt_m] = b;
        bcnt_m++;
        if (bcnt_m == 4) begin
            ram_m[load_ptr_m] = {bytes_m[3], bytes_m[2], bytes_m[1], bytes_m[0]};
            load_ptr_m = (load_ptr_m + 1) % 256;
            bcnt_m = 0;
        end
    endtask

    task automatic uart_send(input logic [7:0] b, input bit stop_ok, input bit accepted);
        uart_rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) tick();
        end
        uart_rx = stop_ok;
        repeat (CPB) tick();
        uart_rx = 1'b1;
        repeat (CPB) tick();
        if (stop_ok && accepted) model_byte(b);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) uart_send(w[8*i +: 8], 1'b1, 1'b1);
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (state_out == 3'd0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic do_reset();
        fsm_rst = 1'b0;
        #30;
        fsm_rst = 1'b1;
        tick();
        model_reset();
    endtask

    // instructions retired when run is sampled high on e consecutive edges starting from IDLE
    function automatic int instrs_for(input int e);
        return (e - 1) / 3 + 1;
    endfunction

    task automatic test_reset();
        fsm_rst = 1'b0;
        #100;
        fsm_rst = 1'b1;
        tick();
        model_reset();
        n_vec++; if (state_out !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", state_out); end
        n_vec++; if (pc_out !== 8'd0) begin n_err++; $display("FAIL reset_pc: got %0d expected 0", pc_out); end
        n_vec++; if (curr_instr_out !== 32'h0) begin n_err++; $display("FAIL reset_curr: got %h expected 0", curr_instr_out); end
        n_vec++; if (next_instr_out !== 32'h0) begin n_err++; $display("FAIL reset_next: got %h expected 0", next_instr_out); end
        n_vec++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL reset_uart_tx: got %b expected 1", uart_tx); end
    endtask

    task automatic test_uart_load();
        logic [31:0] spec_w [4];
        logic [31:0] w;
        logic [7:0]  junk;
        spec_w[0] = 32'h8000_0001;
        spec_w[1] = 32'h4000_0002;
        spec_w[2] = 32'h2000_0003;
        spec_w[3] = 32'h1000_0004;
        for (int a = 0; a < 256; a++) begin
            if (a < 4) w = spec_w[a];
            else if (a == 9) w = 32'h0;
            else w = $urandom() & ~32'h0020_0000;
            if (a == 2) begin
                junk = 8'($urandom_range(0, 255));
                uart_send(junk, 1'b0, 1'b1);
            end
            send_word(w);
        end
        n_vec++; if (state_out !== 3'd0) begin n_err++; $display("FAIL load_state: got %0d expected 0", state_out); end
        n_vec++; if (pc_out !== 8'd0) begin n_err++; $display("FAIL load_pc: got %0d expected 0", pc_out); end
    endtask

    task automatic test_step();
        int p0;
        for (int s = 0; s < 10; s++) begin
            p0 = pc_m;
            step = 1'b1;
            tick();
            step = 1'b0;
            n_vec++; if (state_out !== 3'd1) begin n_err++; $display("FAIL step_fetch_state: got %0d expected 1", state_out); end
            tick();
            n_vec++; if (state_out !== 3'd2) begin n_err++; $display("FAIL step_decode_state: got %0d expected 2", state_out); end
            n_vec++; if (curr_instr_out !== ram_m[p0]) begin n_err++; $display("FAIL step_curr: got %h expected %h", curr_instr_out, ram_m[p0]); end
            n_vec++; if (next_instr_out !== ram_m[(p0+1)%256]) begin n_err++; $display("FAIL step_next: got %h expected %h", next_instr_out, ram_m[(p0+1)%256]); end
            tick();
            n_vec++; if (pc_out !== 8'(p0)) begin n_err++; $display("FAIL step_pc_before_exec: got %0d expected %0d", pc_out, p0); end
            tick();
            pc_m = (p0 + 1) % 256;
            n_vec++; if (state_out !== 3'd0) begin n_err++; $display("FAIL step_idle_state: got %0d expected 0", state_out); end
            n_vec++; if (pc_out !== 8'(pc_m)) begin n_err++; $display("FAIL step_pc: got %0d expected %0d", pc_out, pc_m); end
        end
        n_vec++; if (curr_instr_out !== 32'h0) begin n_err++; $display("FAIL step10_curr: got %h expected 0", curr_instr_out); end
    endtask

    task automatic test_run();
        int p0;
        int ep;
        p0 = pc_m;
        run = 1'b1;
        for (int i = 0; i < 24; i++) begin
            step = (i < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            ep = (p0 + i / 3) % 256;
            n_vec++; if (state_out !== 3'(i % 3 + 1)) begin n_err++; $display("FAIL run_state: got %0d expected %0d", state_out, i % 3 + 1); end
            n_vec++; if (pc_out !== 8'(ep)) begin n_err++; $display("FAIL run_pc: got %0d expected %0d", pc_out, ep); end
            if (i % 3 == 1) begin
                n_vec++; if (curr_instr_out !== ram_m[ep]) begin n_err++; $display("FAIL run_curr: got %h expected %h", curr_instr_out, ram_m[ep]); end
            end
        end
        run = 1'b0;
        tick();
        pc_m = (p0 + 8) % 256;
        n_vec++; if (state_out !== 3'd0) begin n_err++; $display("FAIL run_end_state: got %0d expected 0", state_out); end
        n_vec++; if (pc_out !== 8'(pc_m)) begin n_err++; $display("FAIL run_end_pc: got %0d expected %0d", pc_out, pc_m); end
    endtask

    task automatic test_wrap();
        int  n;
        bit  ok;
        n = 255 - pc_m;
        run = 1'b1;
        repeat (3 * n - 2) tick();
        run = 1'b0;
        wait_idle(ok);
        pc_m = 255;
        n_vec++; if (!ok) begin n_err++; $display("FAIL wrap_idle_timeout: got state %0d expected 0", state_out); end
        n_vec++; if (pc_out !== 8'd255) begin n_err++; $display("FAIL wrap_pc255: got %0d expected 255", pc_out); end
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        n_vec++; if (curr_instr_out !== ram_m[255]) begin n_err++; $display("FAIL wrap_curr: got %h expected %h", curr_instr_out, ram_m[255]); end
        n_vec++; if (next_instr_out !== ram_m[0]) begin n_err++; $display("FAIL wrap_next: got %h expected %h", next_instr_out, ram_m[0]); end
        tick();
        tick();
        pc_m = 0;
        n_vec++; if (pc_out !== 8'd0) begin n_err++; $display("FAIL wrap_pc0: got %0d expected 0", pc_out); end
        n_vec++; if (state_out !== 3'd0) begin n_err++; $display("FAIL wrap_state: got %0d expected 0", state_out); end
    endtask

    task automatic test_drop_while_busy();
        logic [7:0] b [5];
        int         t0;
        int         e;
        bit         ok;
        for (int i = 0; i < 5; i++) b[i] = 8'($urandom_range(0, 255));
        b[3] = b[3] & 8'hDF;
        uart_send(b[0], 1'b1, 1'b1);
        uart_send(b[1], 1'b1, 1'b1);
        t0 = ticks;
        run = 1'b1;
        uart_send(b[2], 1'b1, 1'b0);
        e = ticks - t0;
        run = 1'b0;
        wait_idle(ok);
        pc_m = (pc_m + instrs_for(e)) % 256;
        n_vec++; if (!ok) begin n_err++; $display("FAIL drop_idle_timeout: got state %0d expected 0", state_out); end
        n_vec++; if (pc_out !== 8'(pc_m)) begin n_err++; $display("FAIL drop_run_pc: got %0d expected %0d", pc_out, pc_m); end
        uart_send(b[3], 1'b1, 1'b1);
        uart_send(b[4], 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid_exec();
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        tick();
        n_vec++; if (state_out !== 3'd3) begin n_err++; $display("FAIL rstexec_pre_state: got %0d expected 3", state_out); end
        #5;
        fsm_rst = 1'b0;
        #1;
        n_vec++; if (state_out !== 3'd0) begin n_err++; $display("FAIL rstexec_state: got %0d expected 0", state_out); end
        n_vec++; if (pc_out !== 8'd0) begin n_err++; $display("FAIL rstexec_pc: got %0d expected 0", pc_out); end
        n_vec++; if (curr_instr_out !== 32'h0) begin n_err++; $display("FAIL rstexec_curr: got %h expected 0", curr_instr_out); end
        n_vec++; if (next_instr_out !== 32'h0) begin n_err++; $display("FAIL rstexec_next: got %h expected 0", next_instr_out); end
        #20;
        fsm_rst = 1'b1;
        model_reset();
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        n_vec++; if (curr_instr_out !== ram_m[0]) begin n_err++; $display("FAIL rstexec_ram0: got %h expected %h", curr_instr_out, ram_m[0]); end
        n_vec++; if (next_instr_out !== ram_m[1]) begin n_err++; $display("FAIL rstexec_ram1: got %h expected %h", next_instr_out, ram_m[1]); end
        tick();
        tick();
        pc_m = 1;
        n_vec++; if (pc_out !== 8'd1) begin n_err++; $display("FAIL rstexec_pc_after: got %0d expected 1", pc_out); end
    endtask

    task automatic test_halt_decode();
        int p0;
        p0 = pc_m;
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        n_vec++; if (state_out !== 3'd2) begin n_err++; $display("FAIL haltdec_decode: got %0d expected 2", state_out); end
        halt = 1'b1;
        tick();
        halt = 1'b0;
        n_vec++; if (state_out !== 3'd3) begin n_err++; $display("FAIL haltdec_exec: got %0d expected 3", state_out); end
        tick();
        n_vec++; if (state_out !== 3'd5) begin n_err++; $display("FAIL haltdec_halted: got %0d expected 5", state_out); end
        n_vec++; if (pc_out !== 8'(p0 + 1)) begin n_err++; $display("FAIL haltdec_pc: got %0d expected %0d", pc_out, p0 + 1); end
        run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step = ~step;
            tick();
        end
        run = 1'b0;
        step = 1'b0;
        tick();
        n_vec++; if (state_out !== 3'd5) begin n_err++; $display("FAIL haltdec_sticky: got %0d expected 5", state_out); end
        n_vec++; if (pc_out !== 8'(p0 + 1)) begin n_err++; $display("FAIL haltdec_frozen_pc: got %0d expected %0d", pc_out, p0 + 1); end
        n_vec++; if (curr_instr_out !== ram_m[p0]) begin n_err++; $display("FAIL haltdec_frozen_curr: got %h expected %h", curr_instr_out, ram_m[p0]); end
    endtask

    task automatic test_halt_instr();
        do_reset();
        send_word(32'h0020_0000);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        tick();
        tick();
        n_vec++; if (state_out !== 3'd5) begin n_err++; $display("FAIL haltins_state: got %0d expected 5", state_out); end
        n_vec++; if (pc_out !== 8'd1) begin n_err++; $display("FAIL haltins_pc: got %0d expected 1", pc_out); end
        n_vec++; if (curr_instr_out !== ram_m[0]) begin n_err++; $display("FAIL haltins_curr: got %h expected %h", curr_instr_out, ram_m[0]); end
        run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step = ~step;
            tick();
        end
        run = 1'b0;
        step = 1'b0;
        tick();
        n_vec++; if (state_out !== 3'd5) begin n_err++; $display("FAIL haltins_sticky: got %0d expected 5", state_out); end
        n_vec++; if (pc_out !== 8'd1) begin n_err++; $display("FAIL haltins_frozen_pc: got %0d expected 1", pc_out); end
    endtask

    task automatic test_halt_idle();
        do_reset();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        n_vec++; if (state_out !== 3'd5) begin n_err++; $display("FAIL haltidle_state: got %0d expected 5", state_out); end
        n_vec++; if (pc_out !== 8'd0) begin n_err++; $display("FAIL haltidle_pc: got %0d expected 0", pc_out); end
        repeat (3) tick();
        n_vec++; if (state_out !== 3'd5) begin n_err++; $display("FAIL haltidle_sticky: got %0d expected 5", state_out); end
    endtask

    initial begin
        test_reset();
        test_uart_load();
        test_step();
        test_run();
        test_wrap();
        test_drop_while_busy();
        test_reset_mid_exec();
        test_halt_decode();
        test_halt_instr();
        test_halt_idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
